// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// drives datapath enables and selects, stalls on memory, traps illegal opcodes and timeouts.
`timescale 1ns/1ps
module mips_multicycle_ctrl #(
  parameter int unsigned INST_W      = 32,
  parameter int unsigned ALUOP_W     = 4,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INST_W-1:0]  inst,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               PCen,
  output logic [1:0]         PCSrc,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               MemToReg,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               illegal_inst,
  output logic               mem_timeout,
  output logic [CNT_W-1:0]   retire_cnt,
  output logic [3:0]         state
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(4);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    R_EXEC  = 4'd2,
    R_WB    = 4'd3,
    ADDR    = 4'd4,
    MEM_RD  = 4'd5,
    MEM_WB  = 4'd6,
    MEM_WR  = 4'd7,
    I_WB    = 4'd8,
    BRANCH  = 4'd9,
    JUMP    = 4'd10,
    ILLEGAL = 4'd14,
    FAULT   = 4'd15
  } state_t;

  state_t            curState, nextState;
  logic [WAIT_W-1:0] waitCnt;
  logic              retire;
  logic              waitHit;
  logic              isWaitState;
  logic              functLegal;
  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic              unusedInst;

  assign opcode     = inst[INST_W-1 -: 6];
  assign funct      = inst[5:0];
  assign unusedInst = ^inst[INST_W-7:6];
  assign state      = curState;

  assign functLegal  = (funct == 6'b100000) || (funct == 6'b100010) || (funct == 6'b100100) ||
                       (funct == 6'b100101) || (funct == 6'b101010);
  assign isWaitState = (curState == FETCH) || (curState == MEM_RD) || (curState == MEM_WR);
  // Limit reached and memory still busy; a ready on the same cycle wins.
  assign waitHit     = (MEM_TIMEOUT != 0) && (waitCnt == WAIT_W'(MEM_TIMEOUT)) && !mem_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) curState <= FETCH;
    else        curState <= nextState;
  end

  always_comb begin
    nextState = curState;
    retire    = 1'b0;
    case (curState)
      FETCH:  if (waitHit) nextState = FAULT; else if (mem_ready) nextState = DECODE;
      DECODE: begin
        case (opcode)
          OP_RTYPE:             nextState = functLegal ? R_EXEC : ILLEGAL;
          OP_LW, OP_SW, OP_ADDI: nextState = ADDR;
          OP_BEQ, OP_BNE:       nextState = BRANCH;
          OP_J:                 nextState = JUMP;
          default:              nextState = ILLEGAL;
        endcase
      end
      R_EXEC: nextState = R_WB;
      ADDR: begin
        if (opcode == OP_LW)      nextState = MEM_RD;
        else if (opcode == OP_SW) nextState = MEM_WR;
        else                      nextState = I_WB;
      end
      MEM_RD: if (waitHit) nextState = FAULT; else if (mem_ready) nextState = MEM_WB;
      MEM_WR: begin
        if (waitHit) nextState = FAULT;
        else if (mem_ready) begin
          nextState = FETCH;
          retire    = 1'b1;
        end
      end
      R_WB, MEM_WB, I_WB, BRANCH, JUMP: begin
        nextState = FETCH;
        retire    = 1'b1;
      end
      ILLEGAL, FAULT: nextState = curState;
      default:        nextState = FETCH;
    endcase
  end

  // Wait counter, retirement counter and sticky fault flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      waitCnt      <= '0;
      retire_cnt   <= '0;
      illegal_inst <= 1'b0;
      mem_timeout  <= 1'b0;
    end else begin
      if (isWaitState && !mem_ready && (nextState == curState)) waitCnt <= waitCnt + WAIT_W'(1);
      else                                                       waitCnt <= '0;
      if (retire)                retire_cnt   <= retire_cnt + CNT_W'(1);
      if (nextState == ILLEGAL)  illegal_inst <= 1'b1;
      if (nextState == FAULT)    mem_timeout  <= 1'b1;
    end
  end

  always_comb begin
    PCen     = 1'b0;
    PCSrc    = 2'b00;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    RegWrite = 1'b0;
    MemToReg = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = ALU_ADD;
    if (rst_n) begin
      case (curState)
        FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCen    = mem_ready;
        end
        DECODE: ALUSrcB = 2'b11;
        R_EXEC: begin
          ALUSrcA = 1'b1;
          case (funct)
            6'b100010: ALUOp = ALU_SUB;
            6'b100100: ALUOp = ALU_AND;
            6'b100101: ALUOp = ALU_OR;
            6'b101010: ALUOp = ALU_SLT;
            default:   ALUOp = ALU_ADD;
          endcase
        end
        R_WB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        MEM_RD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        MEM_WB: begin
          RegWrite = 1'b1;
          MemToReg = 1'b1;
        end
        MEM_WR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        I_WB:   RegWrite = 1'b1;
        BRANCH: begin
          ALUSrcA = 1'b1;
          ALUOp   = ALU_SUB;
          PCSrc   = 2'b01;
          PCen    = (opcode == OP_BNE) ? ~zero : zero;
        end
        JUMP: begin
          PCSrc = 2'b10;
          PCen  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: directed scenarios plus a randomized
// instruction stream checked against an instruction-level state-path model.
`timescale 1ns/1ps
module tb_mips_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst;
  logic        zero;
  logic        memReady;

  logic        PCen, IorD, MemRead, MemWrite, IRWrite, RegDst, RegWrite, MemToReg, ALUSrcA;
  logic [1:0]  PCSrc, ALUSrcB;
  logic [3:0]  ALUOp, state;
  logic        illegalInst, memTimeout;
  logic [15:0] retireCnt;

  logic        z_MemRead, z_memTimeout;
  logic [3:0]  z_state;
  logic [16:0] unusedZ;
  logic [15:0] unusedZCnt;

  logic [3:0]  w_retireCnt, w_state;
  logic [18:0] unusedW;

  int nChecks = 0;
  int nFail   = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .inst(inst), .zero(zero), .mem_ready(memReady),
    .PCen(PCen), .PCSrc(PCSrc), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegDst(RegDst), .RegWrite(RegWrite), .MemToReg(MemToReg),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .illegal_inst(illegalInst),
    .mem_timeout(memTimeout), .retire_cnt(retireCnt), .state(state)
  );

  mips_multicycle_ctrl #(.MEM_TIMEOUT(0)) dutNoTimeout (
    .clk(clk), .rst_n(rst_n), .inst(inst), .zero(zero), .mem_ready(memReady),
    .PCen(unusedZ[0]), .PCSrc(unusedZ[2:1]), .IorD(unusedZ[3]), .MemRead(z_MemRead),
    .MemWrite(unusedZ[4]), .IRWrite(unusedZ[5]), .RegDst(unusedZ[6]), .RegWrite(unusedZ[7]),
    .MemToReg(unusedZ[8]), .ALUSrcA(unusedZ[9]), .ALUSrcB(unusedZ[11:10]), .ALUOp(unusedZ[15:12]),
    .illegal_inst(unusedZ[16]), .mem_timeout(z_memTimeout), .retire_cnt(unusedZCnt), .state(z_state)
  );

  mips_multicycle_ctrl #(.CNT_W(4)) dutSmallCnt (
    .clk(clk), .rst_n(rst_n), .inst(inst), .zero(zero), .mem_ready(memReady),
    .PCen(unusedW[0]), .PCSrc(unusedW[2:1]), .IorD(unusedW[3]), .MemRead(unusedW[4]),
    .MemWrite(unusedW[5]), .IRWrite(unusedW[6]), .RegDst(unusedW[7]), .RegWrite(unusedW[8]),
    .MemToReg(unusedW[9]), .ALUSrcA(unusedW[10]), .ALUSrcB(unusedW[12:11]), .ALUOp(unusedW[16:13]),
    .illegal_inst(unusedW[17]), .mem_timeout(unusedW[18]), .retire_cnt(w_retireCnt), .state(w_state)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; memReady = 1'b0; zero = 1'b0; inst = 32'h0;
    cyc(); cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; memReady = 1'b1; zero = 1'b1; inst = 32'h0;
    cyc(); cyc();
    #1;
    nChecks++;
    if (state !== 4'd0 || retireCnt !== 16'd0 || illegalInst !== 1'b0 || memTimeout !== 1'b0) begin
      nFail++;
      $display("FAIL reset_state: state=%0d retire=%0d ill=%b tmo=%b, want 0/0/0/0",
               state, retireCnt, illegalInst, memTimeout);
    end
    nChecks++;
    if ({PCen, MemRead, MemWrite, IRWrite, RegWrite, PCSrc, ALUSrcB, ALUSrcA} !== 10'd0) begin
      nFail++;
      $display("FAIL reset_outputs_forced: PCen=%b MemRead=%b IRWrite=%b ALUSrcB=%b, want all 0",
               PCen, MemRead, IRWrite, ALUSrcB);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_rtype();
    int expPath[4] = '{0, 1, 2, 3};
    do_reset();
    inst = 32'h00221820; memReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      nChecks++;
      if (state !== 4'(expPath[i])) begin
        nFail++;
        $display("FAIL rtype_path[%0d]: state=%0d want %0d", i, state, expPath[i]);
      end
      if (i == 0) begin
        nChecks++;
        if ({IRWrite, PCen, MemRead, ALUSrcB} !== 5'b11101) begin
          nFail++;
          $display("FAIL rtype_fetch: IRWrite=%b PCen=%b MemRead=%b ALUSrcB=%b want 1 1 1 01",
                   IRWrite, PCen, MemRead, ALUSrcB);
        end
      end
      if (i == 2) begin
        nChecks++;
        if ({ALUSrcA, ALUSrcB, ALUOp} !== 7'b1_00_0000) begin
          nFail++;
          $display("FAIL rtype_exec: ALUSrcA=%b ALUSrcB=%b ALUOp=%b want 1 00 0000", ALUSrcA, ALUSrcB, ALUOp);
        end
      end
      if (i == 3) begin
        nChecks++;
        if ({RegWrite, RegDst, MemToReg} !== 3'b110) begin
          nFail++;
          $display("FAIL rtype_wb: RegWrite=%b RegDst=%b MemToReg=%b want 110", RegWrite, RegDst, MemToReg);
        end
      end
      cyc();
    end
    nChecks++;
    if (state !== 4'd0 || retireCnt !== 16'd1) begin
      nFail++;
      $display("FAIL rtype_retire: state=%0d retire=%0d want 0/1", state, retireCnt);
    end
  endtask

  task automatic test_lw_stall();
    int rdCycles = 0;
    int wbCycles = 0;
    do_reset();
    inst = 32'h8C220004;
    // Cycles: FETCH, DECODE, ADDR, three MEM_RD stalls, MEM_RD completes, MEM_WB.
    for (int c = 0; c < 8; c++) begin
      memReady = !(c >= 3 && c <= 5);
      #1;
      if (MemRead && IorD) rdCycles++;
      if (RegWrite && MemToReg && !RegDst) wbCycles++;
      cyc();
    end
    nChecks++;
    if (rdCycles != 4) begin
      nFail++;
      $display("FAIL lw_memrd_cycles: got %0d want 4", rdCycles);
    end
    nChecks++;
    if (wbCycles != 1) begin
      nFail++;
      $display("FAIL lw_memwb_cycles: got %0d want 1", wbCycles);
    end
    nChecks++;
    if (state !== 4'd0 || memTimeout !== 1'b0 || retireCnt !== 16'd1) begin
      nFail++;
      $display("FAIL lw_end: state=%0d tmo=%b retire=%0d want 0/0/1", state, memTimeout, retireCnt);
    end
  endtask

  task automatic test_branch();
    logic [31:0] insts[4] = '{32'h10220003, 32'h10220003, 32'h14220003, 32'h14220003};
    logic        zs[4]    = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic        expPc;
    do_reset();
    memReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      inst = insts[k]; zero = zs[k];
      cyc(); cyc();
      #1;
      expPc = (k < 2) ? zs[k] : !zs[k];
      nChecks++;
      if (state !== 4'd9 || PCSrc !== 2'b01 || PCen !== expPc || ALUOp !== 4'b0001) begin
        nFail++;
        $display("FAIL branch[%0d]: state=%0d PCSrc=%b PCen=%b ALUOp=%b want 9 01 %b 0001",
                 k, state, PCSrc, PCen, ALUOp, expPc);
      end
      cyc();
      nChecks++;
      if (state !== 4'd0 || retireCnt !== 16'(k + 1)) begin
        nFail++;
        $display("FAIL branch_retire[%0d]: state=%0d retire=%0d want 0/%0d", k, state, retireCnt, k + 1);
      end
    end
  endtask

  task automatic test_illegal();
    logic [31:0] bad[2] = '{32'hFC000000, 32'h00221821};
    for (int b = 0; b < 2; b++) begin
      do_reset();
      inst = bad[b]; memReady = 1'b1;
      cyc(); cyc();
      for (int i = 0; i < 20; i++) begin
        #1;
        nChecks++;
        if (state !== 4'd14 || illegalInst !== 1'b1 ||
            {PCen, MemRead, MemWrite, IRWrite, RegWrite} !== 5'd0) begin
          nFail++;
          $display("FAIL illegal_hold[%0d.%0d]: state=%0d ill=%b PCen=%b MemRead=%b RegWrite=%b",
                   b, i, state, illegalInst, PCen, MemRead, RegWrite);
        end
        cyc();
      end
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      nChecks++;
      if (state !== 4'd0 || illegalInst !== 1'b0 || retireCnt !== 16'd0) begin
        nFail++;
        $display("FAIL illegal_clear[%0d]: state=%0d ill=%b retire=%0d want 0/0/0",
                 b, state, illegalInst, retireCnt);
      end
    end
  endtask

  task automatic test_timeout();
    // 15 stall cycles are tolerated; the 16th stalled cycle (counter at the limit) faults.
    localparam int LIMIT = 15;
    do_reset();
    for (int i = 0; i < LIMIT; i++) cyc();
    nChecks++;
    if (state !== 4'd0 || memTimeout !== 1'b0) begin
      nFail++;
      $display("FAIL timeout_early: state=%0d tmo=%b want 0/0", state, memTimeout);
    end
    cyc();
    nChecks++;
    if (state !== 4'd15 || memTimeout !== 1'b1 || MemRead !== 1'b0) begin
      nFail++;
      $display("FAIL timeout_fault: state=%0d tmo=%b MemRead=%b want 15/1/0", state, memTimeout, MemRead);
    end
    for (int i = 0; i < 100; i++) cyc();
    nChecks++;
    if (z_state !== 4'd0 || z_memTimeout !== 1'b0 || z_MemRead !== 1'b1) begin
      nFail++;
      $display("FAIL no_timeout_stall: state=%0d tmo=%b MemRead=%b want 0/0/1", z_state, z_memTimeout, z_MemRead);
    end
    nChecks++;
    if (state !== 4'd15 || retireCnt !== 16'd0) begin
      nFail++;
      $display("FAIL timeout_sticky: state=%0d retire=%0d want 15/0", state, retireCnt);
    end
    do_reset();
    for (int i = 0; i < LIMIT; i++) cyc();
    memReady = 1'b1;
    cyc();
    nChecks++;
    if (state !== 4'd1 || memTimeout !== 1'b0) begin
      nFail++;
      $display("FAIL timeout_ready_at_limit: state=%0d tmo=%b want 1/0", state, memTimeout);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    inst = 32'h08000000; memReady = 1'b1;
    for (int i = 0; i < 17 * 3; i++) cyc();
    nChecks++;
    if (w_retireCnt !== 4'(17) || w_state !== 4'd0) begin
      nFail++;
      $display("FAIL retire_wrap: retire=%0d state=%0d want %0d/0", w_retireCnt, w_state, 17 % 16);
    end
    nChecks++;
    if (retireCnt !== 16'd17) begin
      nFail++;
      $display("FAIL retire_17: retire=%0d want 17", retireCnt);
    end
  endtask

  task automatic test_reset_mid_wr();
    do_reset();
    inst = 32'hAC220004; memReady = 1'b1;
    cyc(); cyc(); cyc();
    memReady = 1'b0;
    #1;
    nChecks++;
    if (state !== 4'd7 || MemWrite !== 1'b1 || IorD !== 1'b1) begin
      nFail++;
      $display("FAIL memwr_active: state=%0d MemWrite=%b IorD=%b want 7/1/1", state, MemWrite, IorD);
    end
    cyc();
    rst_n = 1'b0; memReady = 1'b1;
    #1;
    nChecks++;
    if (MemWrite !== 1'b0 || IorD !== 1'b0) begin
      nFail++;
      $display("FAIL memwr_reset_gate: MemWrite=%b IorD=%b want 0/0", MemWrite, IorD);
    end
    cyc();
    rst_n = 1'b1; memReady = 1'b0;
    #1;
    nChecks++;
    if (state !== 4'd0 || retireCnt !== 16'd0) begin
      nFail++;
      $display("FAIL memwr_abandon: state=%0d retire=%0d want 0/0", state, retireCnt);
    end
  endtask

  task automatic test_random();
    logic [5:0]  ops[7]    = '{6'h00, 6'h23, 6'h2B, 6'h08, 6'h04, 6'h05, 6'h02};
    logic [5:0]  functs[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    int          modelRetire = 0;
    int          path[$];
    int          cls, fi, k, waitRun, guard, e;
    logic [31:0] body;
    logic [5:0]  exp, got;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      cls  = $urandom_range(0, 6);
      fi   = $urandom_range(0, 4);
      body = $urandom;
      inst = {ops[cls], body[25:0]};
      if (cls == 0) inst[5:0] = functs[fi];
      case (cls)
        0:       path = '{0, 1, 2, 3};
        1:       path = '{0, 1, 4, 5, 6};
        2:       path = '{0, 1, 4, 7};
        3:       path = '{0, 1, 4, 8};
        4, 5:    path = '{0, 1, 9};
        default: path = '{0, 1, 10};
      endcase
      k = 0; waitRun = 0; guard = 0;
      while (k < path.size() && guard < 100) begin
        guard++;
        e        = path[k];
        memReady = (waitRun >= 5) ? 1'b1 : ($urandom_range(0, 2) != 0);
        zero     = 1'($urandom_range(0, 1));
        #1;
        nChecks++;
        if (state !== 4'(e)) begin
          nFail++;
          $display("FAIL rand_state[%0d] cls=%0d: state=%0d want %0d", n, cls, state, e);
        end
        exp = {e == 3 || e == 6 || e == 8, e == 7, e == 0 || e == 5,
               e == 0 && memReady, e == 6,
               (e == 0 && memReady) || e == 10 || (e == 9 && ((cls == 4) ? zero : !zero))};
        got = {RegWrite, MemWrite, MemRead, IRWrite, MemToReg, PCen};
        nChecks++;
        if (got !== exp) begin
          nFail++;
          $display("FAIL rand_strobes[%0d] cls=%0d st=%0d: {RegWr,MemWr,MemRd,IRWr,M2R,PCen}=%b want %b",
                   n, cls, e, got, exp);
        end
        if (e == 2) begin
          nChecks++;
          if (ALUOp !== 4'(fi)) begin
            nFail++;
            $display("FAIL rand_aluop[%0d]: ALUOp=%0d want %0d", n, ALUOp, fi);
          end
        end
        if ((e == 0 || e == 5 || e == 7) && !memReady) waitRun++;
        else begin
          waitRun = 0;
          k++;
        end
        cyc();
      end
      if (guard >= 100) begin
        nChecks++;
        nFail++;
        $display("FAIL rand_guard[%0d]: instruction did not complete in 100 cycles", n);
      end
      modelRetire++;
      nChecks++;
      if (retireCnt !== 16'(modelRetire)) begin
        nFail++;
        $display("FAIL rand_retire[%0d]: retire=%0d want %0d", n, retireCnt, modelRetire);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; inst = 32'h0; zero = 1'b0; memReady = 1'b0;
    test_reset();
    test_rtype();
    test_lw_stall();
    test_branch();
    test_illegal();
    test_timeout();
    test_wrap();
    test_reset_mid_wr();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
